// File: rtl/fp_dispatch_if.sv
// Purpose: bundles the op FIFO head, the FP unit start/done strobes, the
//          result FIFO credit return and the status flags of fp_dispatch.
// Ports (signals):
//   op_valid/op_code/op_a/op_b   op FIFO head (to dispatcher)
//   op_pop                       1-cycle pop strobe (from dispatcher)
//   unit_a/unit_b/cos_sel        latched operands and sine/cosine select
//   add/mul/sine_start           1-cycle start strobes
//   add/mul/sine_done            unit result valid
//   res_pop                      consumer pop from result FIFO (credit return)
//   err_clr                      clears sticky error flags
//   busy/credits/err_*           status
//   dbg_state                    dispatcher FSM state, for observation only
// Handshake: a start strobe is a single-cycle request; the selected unit
// answers with a done pulse some cycles later. op_pop and res_pop are
// single-cycle strobes meaning "one entry removed at this clock edge".
interface fp_dispatch_if #(
  parameter int DATA_W    = 32,
  parameter int OUT_DEPTH = 8
);
  localparam int CW = $clog2(OUT_DEPTH) + 1;

  logic              op_valid;
  logic [2:0]        op_code;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_pop;
  logic [DATA_W-1:0] unit_a;
  logic [DATA_W-1:0] unit_b;
  logic              cos_sel;
  logic              add_start;
  logic              mul_start;
  logic              sine_start;
  logic              add_done;
  logic              mul_done;
  logic              sine_done;
  logic              res_pop;
  logic              err_clr;
  logic              busy;
  logic [CW-1:0]     credits;
  logic              err_opcode;
  logic              err_timeout;
  logic [2:0]        dbg_state;

  modport master (
    input  op_valid, op_code, op_a, op_b,
    input  add_done, mul_done, sine_done,
    input  res_pop, err_clr,
    output op_pop, unit_a, unit_b, cos_sel,
    output add_start, mul_start, sine_start,
    output busy, credits, err_opcode, err_timeout, dbg_state
  );

  modport slave (
    output op_valid, op_code, op_a, op_b,
    output add_done, mul_done, sine_done,
    output res_pop, err_clr,
    input  op_pop, unit_a, unit_b, cos_sel,
    input  add_start, mul_start, sine_start,
    input  busy, credits, err_opcode, err_timeout, dbg_state
  );
endinterface

// File: rtl/fp_dispatch.sv
// Purpose: sequencer between the op FIFO and the FP add/mul/sine units.
//          Takes one op at the FIFO head, starts the matching unit, waits for
//          its done, then pops the op FIFO (so the opcode stays visible to the
//          output steering until the result is out). Issue is held off while
//          the result FIFO has no free slot, tracked with a credit counter.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high
//   bus   fp_dispatch_if.master (see interface header for signal list)
module fp_dispatch #(
  parameter int DATA_W    = 32,
  parameter int OUT_DEPTH = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         rst,
  fp_dispatch_if.master bus
);
  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_RETIRE = 3'd3,
    S_DROP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    U_ADD  = 2'd0,
    U_MUL  = 2'd1,
    U_SINE = 2'd2
  } unit_t;

  state_t            r_state;
  unit_t             r_unit;
  logic [TW-1:0]     r_wait_cnt;
  logic [CW-1:0]     r_credits;
  logic [DATA_W-1:0] r_unit_a;
  logic [DATA_W-1:0] r_unit_b;
  logic              r_cos_sel;
  logic              r_add_start;
  logic              r_mul_start;
  logic              r_sine_start;
  logic              r_op_pop;
  logic              r_busy;
  logic              r_err_opcode;
  logic              r_err_timeout;

  logic              w_legal;
  unit_t             w_unit;
  logic              w_is_sub;
  logic              w_is_cos;
  logic              w_room;
  logic              w_sel_done;
  logic              w_timeout;
  logic              w_set_opc;
  logic              w_set_to;
  logic              w_inc;
  logic              w_dec;
  logic [DATA_W-1:0] w_b_in;

  // Opcode decode of the FIFO head.
  always_comb begin
    w_legal  = 1'b1;
    w_unit   = U_ADD;
    w_is_sub = 1'b0;
    w_is_cos = 1'b0;
    case (bus.op_code)
      3'b001: w_legal = 1'b1;
      3'b010: w_is_sub = 1'b1;
      3'b011: w_unit = U_MUL;
      3'b100: w_unit = U_SINE;
      3'b101: begin
        w_unit   = U_SINE;
        w_is_cos = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Only the unit that was started may complete the op.
  always_comb begin
    case (r_unit)
      U_MUL:   w_sel_done = bus.mul_done;
      U_SINE:  w_sel_done = bus.sine_done;
      default: w_sel_done = bus.add_done;
    endcase
  end

  // Subtraction reuses the adder with the sign of B flipped.
  assign w_b_in    = w_is_sub ? {~bus.op_b[DATA_W-1], bus.op_b[DATA_W-2:0]} : bus.op_b;
  assign w_room    = (r_credits < CW'(OUT_DEPTH));
  assign w_timeout = (TIMEOUT != 0) && (r_wait_cnt == TW'(TIMEOUT - 1));
  assign w_set_opc = (r_state == S_IDLE) && bus.op_valid && !w_legal;
  assign w_set_to  = (r_state == S_WAIT) && !w_sel_done && w_timeout;
  assign w_inc     = (r_state == S_RETIRE);
  // A pop coinciding with a retire always cancels it, even at zero credits,
  // since the retiring result is the entry being consumed.
  assign w_dec     = bus.res_pop && ((r_credits != '0) || w_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_unit        <= U_ADD;
      r_wait_cnt    <= '0;
      r_unit_a      <= '0;
      r_unit_b      <= '0;
      r_cos_sel     <= 1'b0;
      r_add_start   <= 1'b0;
      r_mul_start   <= 1'b0;
      r_sine_start  <= 1'b0;
      r_op_pop      <= 1'b0;
      r_busy        <= 1'b0;
      r_err_opcode  <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_add_start  <= 1'b0;
      r_mul_start  <= 1'b0;
      r_sine_start <= 1'b0;
      r_op_pop     <= 1'b0;
      // A new error in the same cycle as err_clr keeps the flag set.
      r_err_opcode  <= w_set_opc | (r_err_opcode  & ~bus.err_clr);
      r_err_timeout <= w_set_to  | (r_err_timeout & ~bus.err_clr);
      case (r_state)
        S_IDLE: begin
          if (bus.op_valid) begin
            if (!w_legal) begin
              r_state  <= S_DROP;
              r_op_pop <= 1'b1;
              r_busy   <= 1'b1;
            end else if (w_room) begin
              r_state      <= S_ISSUE;
              r_unit       <= w_unit;
              r_unit_a     <= bus.op_a;
              r_unit_b     <= w_b_in;
              r_cos_sel    <= w_is_cos;
              r_add_start  <= (w_unit == U_ADD);
              r_mul_start  <= (w_unit == U_MUL);
              r_sine_start <= (w_unit == U_SINE);
              r_busy       <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= '0;
        end
        S_WAIT: begin
          if (w_sel_done) begin
            r_state  <= S_RETIRE;
            r_op_pop <= 1'b1;
          end else if (w_timeout) begin
            r_state  <= S_DROP;
            r_op_pop <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
          end
        end
        S_RETIRE, S_DROP: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_cos_sel <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= '0;
    end else if (w_inc && !w_dec) begin
      r_credits <= r_credits + CW'(1);
    end else if (!w_inc && w_dec) begin
      r_credits <= r_credits - CW'(1);
    end
  end

  assign bus.op_pop      = r_op_pop;
  assign bus.unit_a      = r_unit_a;
  assign bus.unit_b      = r_unit_b;
  assign bus.cos_sel     = r_cos_sel;
  assign bus.add_start   = r_add_start;
  assign bus.mul_start   = r_mul_start;
  assign bus.sine_start  = r_sine_start;
  assign bus.busy        = r_busy;
  assign bus.credits     = r_credits;
  assign bus.err_opcode  = r_err_opcode;
  assign bus.err_timeout = r_err_timeout;
  assign bus.dbg_state   = r_state;
endmodule
